// File: rtl/matrix_frame_loader.sv
// matrix_frame_loader
//
// Upstream stage of the matrix control unit. It takes one operation frame as a
// byte stream: opcode, msize, 25 bytes of matrix 1 and 25 bytes of matrix 2.
// Each part is packed into a 200-bit word and written to the shared operand
// memory at word 0 (instruction), word 1 (matrix 1) and word 2 (matrix 2).
// After the writes it gives up the memory port and pulses cu_start to the
// control unit. It then waits for a fresh rising edge on cu_ready before it
// accepts the next frame.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   in_valid   byte available on in_data
//   in_data    stream byte
//   in_ready   loader accepts a byte this cycle
//   mem_grant  loader owns the memory port (control unit owns it when low)
//   mem_addr   memory word address
//   mem_data   memory write data (zero when not writing)
//   mem_wren   memory write enable
//   cu_start   start request to the control unit, held START_HOLD cycles
//   cu_ready   control unit result-ready, asynchronous to clk
//   busy       frame in progress
//   done       one-cycle pulse at end of frame
//   err        sticky error flag (bad instruction or cu_ready timeout)

module matrix_frame_loader #(
    parameter int N_ELEM     = 25,
    parameter int ELEM_W     = 8,
    parameter int START_HOLD = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic                       mem_grant,
    output logic [1:0]                 mem_addr,
    output logic [N_ELEM*ELEM_W-1:0]   mem_data,
    output logic                       mem_wren,
    output logic                       cu_start,
    input  logic                       cu_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int WORD_W = N_ELEM * ELEM_W;
    localparam int HOLD_W = $clog2(START_HOLD + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RX_INSTR,
        S_WR_INSTR,
        S_RX_M1,
        S_WR_M1,
        S_RX_M2,
        S_WR_M2,
        S_DRAIN,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic [5:0]          byte_cnt_q, byte_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                err_q, err_d;
    logic                started_q, started_d;
    logic                rdy_meta_q, rdy_meta_d;
    logic                rdy_sync_q, rdy_sync_d;
    logic                rdy_prev_q, rdy_prev_d;

    logic rx_state;
    logic accept;
    logic first_accept;
    logic instr_bad;
    logic ready_edge;
    logic wait_expired;
    logic entering;

    // Byte-accepting states; DRAIN accepts but discards.
    assign rx_state = (state_q == S_RX_INSTR) || (state_q == S_RX_M1) ||
                      (state_q == S_RX_M2)    || (state_q == S_DRAIN);
    assign accept       = rx_state && in_valid;
    assign first_accept = (state_q == S_RX_INSTR) && in_valid && (byte_cnt_q == 6'd0);

    // Instruction word is {.., opcode, msize}.
    assign instr_bad = (asm_q[15:8] > 8'd6) || (asm_q[7:0] > 8'd3);

    // prev tracks sync continuously, so a cu_ready that is already high when
    // WAIT is entered produces no edge; only a fresh 0->1 transition counts.
    assign ready_edge   = rdy_sync_q && !rdy_prev_q;
    assign wait_expired = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            asm_q      <= '0;
            byte_cnt_q <= '0;
            hold_cnt_q <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            started_q  <= 1'b0;
            rdy_meta_q <= 1'b0;
            rdy_sync_q <= 1'b0;
            rdy_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            started_q  <= started_d;
            rdy_meta_q <= rdy_meta_d;
            rdy_sync_q <= rdy_sync_d;
            rdy_prev_q <= rdy_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_RX_INSTR;
            S_RX_INSTR: if (accept && byte_cnt_q == 6'd1) state_d = S_WR_INSTR;
            S_WR_INSTR: state_d = instr_bad ? S_DRAIN : S_RX_M1;
            S_RX_M1:    if (accept && byte_cnt_q == 6'(N_ELEM - 1)) state_d = S_WR_M1;
            S_WR_M1:    state_d = S_RX_M2;
            S_RX_M2:    if (accept && byte_cnt_q == 6'(N_ELEM - 1)) state_d = S_WR_M2;
            S_WR_M2:    state_d = S_START;
            S_DRAIN:    if (accept && byte_cnt_q == 6'(2 * N_ELEM - 1)) state_d = S_DONE;
            S_START:    if (hold_cnt_q == HOLD_W'(START_HOLD - 1)) state_d = S_WAIT;
            S_WAIT:     if (ready_edge || wait_expired) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counters, assembly register, flags, synchroniser
    // ------------------------------------------------------------------
    always_comb begin
        entering = (state_d != state_q);

        // Byte counter restarts on every state entry and never wraps.
        byte_cnt_d = byte_cnt_q;
        if (entering)
            byte_cnt_d = '0;
        else if (accept)
            byte_cnt_d = byte_cnt_q + 6'd1;

        // Shift first, then clear on entry to a receive state. The last byte
        // of a word moves to a WR_* state, so it is shifted, never cleared.
        asm_d = asm_q;
        if (accept && state_q != S_DRAIN)
            asm_d = {asm_q[WORD_W-9:0], in_data};
        if (entering && (state_d == S_RX_INSTR || state_d == S_RX_M1 || state_d == S_RX_M2))
            asm_d = '0;

        hold_cnt_d = (state_q == S_START) ? hold_cnt_q + HOLD_W'(1) : '0;
        wait_cnt_d = (state_q == S_WAIT)  ? wait_cnt_q + WAIT_W'(1) : '0;

        err_d = err_q;
        if (first_accept)
            err_d = 1'b0;
        if (state_q == S_WR_INSTR && instr_bad)
            err_d = 1'b1;
        if (state_q == S_WAIT && !ready_edge && wait_expired)
            err_d = 1'b1;

        started_d = started_q;
        if (first_accept)
            started_d = 1'b1;
        if (state_q == S_DONE)
            started_d = 1'b0;

        rdy_meta_d = cu_ready;
        rdy_sync_d = rdy_meta_q;
        rdy_prev_d = rdy_sync_q;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        mem_wren = 1'b0;
        mem_addr = 2'd0;
        cu_start = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_RX_INSTR, S_RX_M1, S_RX_M2, S_DRAIN: in_ready = 1'b1;
            S_WR_INSTR: begin
                mem_wren = !instr_bad;
                mem_addr = 2'd0;
            end
            S_WR_M1: begin
                mem_wren = 1'b1;
                mem_addr = 2'd1;
            end
            S_WR_M2: begin
                mem_wren = 1'b1;
                mem_addr = 2'd2;
            end
            S_START: cu_start = 1'b1;
            S_DONE:  done     = 1'b1;
            default: ;
        endcase

        // busy and grant rise in the cycle the first byte is accepted.
        busy      = (started_q || first_accept) && (state_q != S_DONE);
        mem_grant = busy && (state_q != S_START) && (state_q != S_WAIT);
        mem_data  = mem_wren ? asm_q : '0;
        err       = err_q;
    end

endmodule

// File: tb/tb_matrix_frame_loader.sv
module tb_matrix_frame_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         mem_grant;
    logic [1:0]   mem_addr;
    logic [199:0] mem_data;
    logic         mem_wren;
    logic         cu_start;
    logic         cu_ready;
    logic         busy;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    matrix_frame_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_grant (mem_grant),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wren  (mem_wren),
        .cu_start  (cu_start),
        .cu_ready  (cu_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int checks = 0;
    int passes = 0;

    // Write / done monitor sampled on the falling edge.
    logic [1:0]   wr_addr [64];
    logic [199:0] wr_data [64];
    int           wr_cnt   = 0;
    int           done_cnt = 0;
    int           viol     = 0;

    always @(negedge clk) begin
        if (mem_wren) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_data;
            end
            wr_cnt++;
            if (!mem_grant || in_ready) viol++;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [199:0] pat(input logic [7:0] base, input logic [7:0] step);
        logic [199:0] w;
        w = '0;
        for (int i = 0; i < 25; i++) w = {w[191:0], 8'(base + 8'(i) * step)};
        return w;
    endfunction

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("in_ready_timeout", 1'b0, 1'b1);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] ms,
                              input logic [7:0] b1, input logic [7:0] s1,
                              input logic [7:0] b2, input logic [7:0] s2,
                              input bit gaps);
        send_byte(op, 0);
        chk("err_clear_byte0", err, 1'b0);
        chk("busy_after_byte0", busy, 1'b1);
        send_byte(ms, gaps ? int'($urandom_range(0, 2)) : 0);
        for (int i = 0; i < 25; i++)
            send_byte(8'(b1 + 8'(i) * s1), gaps ? int'($urandom_range(0, 2)) : 0);
        for (int i = 0; i < 25; i++)
            send_byte(8'(b2 + 8'(i) * s2), gaps ? int'($urandom_range(0, 2)) : 0);
        in_valid = 1'b0;
    endtask

    // Starts at the WR_M2 falling edge; measures cu_start, pulses cu_ready
    // 10 cycles after cu_start drops and waits for done.
    task automatic cu_respond(output int hold, output bit grant_seen);
        int t;
        hold = 0;
        grant_seen = 1'b0;
        t = 0;
        while (t < 40) begin
            if (cu_start) begin
                hold++;
                if (mem_grant) grant_seen = 1'b1;
            end else if (hold > 0) begin
                break;
            end
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        cu_ready = 1'b1;
        t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("done_after_ready", done, 1'b1);
        cu_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  base;
        int  dbase;
        int  hold;
        bit  gseen;
        int  t;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        cu_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {in_ready, mem_grant, mem_wren, cu_start, busy, done, err, mem_addr}, '0);
        chk("reset_data", mem_data, '0);
        rst = 1'b1;
        @(negedge clk);

        // ---- SOMA frame, in_valid held high ----
        base = wr_cnt; dbase = done_cnt;
        send_frame(8'h00, 8'h03, 8'h01, 8'h00, 8'h02, 8'h00, 1'b0);
        chk("soma_wr_m2_cycle", {mem_wren, mem_addr, cu_start, in_ready, busy}, {1'b1, 2'd2, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        chk("soma_start_latency", {cu_start, mem_grant, mem_wren}, 3'b100);
        cu_respond(hold, gseen);
        chk("soma_start_hold", hold, 4);
        chk("soma_grant_in_start", gseen, 1'b0);
        @(negedge clk);
        chk("soma_wr_count", wr_cnt - base, 3);
        chk("soma_addr_order", {wr_addr[base], wr_addr[base+1], wr_addr[base+2]}, 6'b00_01_10);
        chk("soma_addr0", wr_data[base], 200'h0003);
        chk("soma_addr1", wr_data[base+1], {25{8'h01}});
        chk("soma_addr2", wr_data[base+2], {25{8'h02}});
        chk("soma_err", err, 1'b0);
        chk("soma_done_cnt", done_cnt - dbase, 1);

        // ---- Ramp M1 with random in_valid gaps ----
        base = wr_cnt;
        send_frame(8'h01, 8'h02, 8'h00, 8'h01, 8'h10, 8'h00, 1'b1);
        cu_respond(hold, gseen);
        @(negedge clk);
        chk("ramp_wr_count", wr_cnt - base, 3);
        chk("ramp_addr0", wr_data[base], 200'h0102);
        chk("ramp_m1_first", wr_data[base+1][199:192], 8'h00);
        chk("ramp_m1_last", wr_data[base+1][7:0], 8'h18);
        chk("ramp_m1_word", wr_data[base+1], pat(8'h00, 8'h01));
        chk("ramp_m2_word", wr_data[base+2], {25{8'h10}});

        // ---- Bad opcode: drain 50 bytes, no writes ----
        base = wr_cnt; dbase = done_cnt;
        send_frame(8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("bad_done_after_52", done, 1'b1);
        chk("bad_err", err, 1'b1);
        @(negedge clk);
        chk("bad_no_writes", wr_cnt - base, 0);
        chk("bad_done_cnt", done_cnt - dbase, 1);
        chk("bad_idle", {busy, done}, 2'b00);
        send_frame(8'h03, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 1'b0);
        cu_respond(hold, gseen);

        // ---- cu_ready stuck high: timeout ----
        cu_ready = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        t = 0;
        while (!done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("timeout_cycles", t, 4101);
        chk("timeout_err", {done, err}, 2'b11);
        @(negedge clk);
        chk("timeout_idle", {busy, done, err}, 3'b001);
        cu_ready = 1'b0;

        // ---- Reset after byte 30 ----
        for (int i = 0; i < 31; i++) send_byte(8'(i), 0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midreset_ctrl", {in_ready, mem_grant, mem_wren, cu_start, busy, done, err, mem_addr}, '0);
        chk("midreset_data", mem_data, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        base = wr_cnt;
        send_frame(8'h01, 8'h02, 8'h20, 8'h01, 8'h40, 8'h01, 1'b0);
        cu_respond(hold, gseen);
        chk("postreset_first_addr", wr_addr[base], 2'd0);
        chk("postreset_addr0", wr_data[base], 200'h0102);
        chk("postreset_m1", wr_data[base+1], pat(8'h20, 8'h01));
        chk("postreset_m2", wr_data[base+2], pat(8'h40, 8'h01));

        // ---- Back-to-back frames ----
        base = wr_cnt; dbase = done_cnt;
        send_frame(8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 1'b0);
        cu_respond(hold, gseen);
        send_frame(8'h05, 8'h03, 8'h07, 8'h00, 8'h08, 8'h00, 1'b0);
        cu_respond(hold, gseen);
        @(negedge clk);
        chk("b2b_wr_count", wr_cnt - base, 6);
        chk("b2b_addr_seq", {wr_addr[base], wr_addr[base+1], wr_addr[base+2],
                             wr_addr[base+3], wr_addr[base+4], wr_addr[base+5]}, 12'b00_01_10_00_01_10);
        chk("b2b_instr0", wr_data[base], 200'h0200);
        chk("b2b_instr1", wr_data[base+3], 200'h0503);
        chk("b2b_m2_second", wr_data[base+5], {25{8'h08}});
        chk("b2b_done_cnt", done_cnt - dbase, 2);

        chk("wren_grant_ready_rule", viol, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
